// File: rtl/seq_mult_param.sv
// seq_mult_param: digit-serial multiplier that consumes DIG_W bits of operand A
// per clock and accumulates the shifted partial products. A result takes
// N = A_W/DIG_W cycles in CALC, followed by a one-cycle DONE pulse.
//
// Optional build macro: SEQ_MULT_SIGNED_EN
//   undefined : a and b are unsigned
//   defined   : a and b are two's complement; product is the signed result,
//               sign-extended to A_W+B_W bits
// Latency and handshake are the same in both builds.
//
// state | code   | meaning
// IDLE  | 3'b000 | waiting for start, operands not yet latched
// CALC  | 3'b001 | one digit of A processed per cycle
// DONE  | 3'b100 | product updated, done pulses for this one cycle
// ERR   | 3'b101 | start seen mid-calculation, waiting for a fresh start
// other codes are illegal and recover through ERR
module seq_mult_param #(
  parameter int A_W   = 8,
  parameter int B_W   = 8,
  parameter int DIG_W = 4
) (
  input  logic                              clk,
  input  logic                              reset_a,
  input  logic                              start,
  input  logic [A_W-1:0]                    a,
  input  logic [B_W-1:0]                    b,
  output logic [A_W+B_W-1:0]                product,
  output logic                              done,
  output logic                              busy,
  output logic                              err,
  output logic [2:0]                        state_out,
  output logic [$clog2(A_W/DIG_W)-1:0]      count_out
);

  localparam int N     = A_W / DIG_W;
  localparam int CNT_W = $clog2(N);
  localparam int P_W   = A_W + B_W;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE = 3'b000,
    CALC = 3'b001,
    DONE = 3'b100,
    ERR  = 3'b101
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [A_W-1:0]    a_reg;
  logic [B_W-1:0]    b_reg;
  logic [P_W-1:0]    acc;
  logic [P_W-1:0]    acc_nxt;
  logic [CNT_W-1:0]  count;

  logic              load;
  logic              last;
  logic [31:0]       shamt;
  logic [DIG_W-1:0]  digit;
  logic [P_W-1:0]    digit_ext;
  logic [P_W-1:0]    b_ext;
  logic [P_W-1:0]    partial;

  // State register
  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; abort on start has priority over finishing in CALC
  always_comb begin
    state_nxt = ERR;
    case (state)
      IDLE:    state_nxt = start ? CALC : IDLE;
      CALC: begin
        if (start) begin
          state_nxt = ERR;
        end else if (last) begin
          state_nxt = DONE;
        end else begin
          state_nxt = CALC;
        end
      end
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = start ? CALC : ERR;
      default: state_nxt = ERR;
    endcase
  end

  // Status outputs decode only the registered state, never start
  always_comb begin
    busy      = (state == CALC);
    done      = (state == DONE);
    err       = (state == ERR);
    state_out = state;
    count_out = count;
  end

  assign load = ((state == IDLE) || (state == ERR)) && start;
  assign last = (count == CNT_LAST);

  // Partial product for the current digit, accumulated modulo 2^P_W.
  // In the signed build only the top digit of A carries negative weight;
  // the lower digits stay unsigned, and b is sign-extended throughout.
  always_comb begin
    shamt     = 32'(count) * 32'(DIG_W);
    digit     = DIG_W'(a_reg >> shamt);
    digit_ext = {{(P_W-DIG_W){1'b0}}, digit};
    b_ext     = {{A_W{1'b0}}, b_reg};
`ifdef SEQ_MULT_SIGNED_EN
    if (last) begin
      digit_ext = {{(P_W-DIG_W){digit[DIG_W-1]}}, digit};
    end
    b_ext     = {{A_W{b_reg[B_W-1]}}, b_reg};
`endif
    partial   = digit_ext * b_ext;
    acc_nxt   = acc + (partial << shamt);
  end

  // Operand latch, accumulator, digit counter and result register
  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      a_reg   <= '0;
      b_reg   <= '0;
      acc     <= '0;
      count   <= '0;
      product <= '0;
    end else if (load) begin
      a_reg <= a;
      b_reg <= b;
      acc   <= '0;
      count <= '0;
    end else if (state == CALC) begin
      if (start) begin
        // aborted: drop the partial sum, product keeps the last good result
        acc   <= '0;
        count <= '0;
      end else if (last) begin
        product <= acc_nxt;
        acc     <= '0;
        count   <= '0;
      end else begin
        acc   <= acc_nxt;
        count <= count + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_seq_mult_param.sv
// Directed bench for seq_mult_param: one default-width instance (A_W=8) and
// one wide instance (A_W=16, B_W=8) sharing clock and reset.
module tb_seq_mult_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_a;

  logic        start8;
  logic [7:0]  a8, b8;
  logic [15:0] product8;
  logic        done8, busy8, err8;
  logic [2:0]  state8;
  logic [0:0]  count8;

  logic        start16;
  logic [15:0] a16;
  logic [7:0]  b16;
  logic [23:0] product16;
  logic        done16, busy16, err16;
  logic [2:0]  state16;
  logic [1:0]  count16;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef SEQ_MULT_SIGNED_EN
  localparam logic [15:0] EXP_FF_FF   = 16'h0001;
  localparam logic [15:0] EXP_FF_02   = 16'hFFFE;
  localparam logic [23:0] EXP_FFFF_FF = 24'h000001;
`else
  localparam logic [15:0] EXP_FF_FF   = 16'hFE01;
  localparam logic [15:0] EXP_FF_02   = 16'h01FE;
  localparam logic [23:0] EXP_FFFF_FF = 24'hFEFF01;
`endif

  seq_mult_param u_mult8 (
    .clk       (clk),
    .reset_a   (reset_a),
    .start     (start8),
    .a         (a8),
    .b         (b8),
    .product   (product8),
    .done      (done8),
    .busy      (busy8),
    .err       (err8),
    .state_out (state8),
    .count_out (count8)
  );

  seq_mult_param #(.A_W(16), .B_W(8), .DIG_W(4)) u_mult16 (
    .clk       (clk),
    .reset_a   (reset_a),
    .start     (start16),
    .a         (a16),
    .b         (b16),
    .product   (product16),
    .done      (done16),
    .busy      (busy16),
    .err       (err16),
    .state_out (state16),
    .count_out (count16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start pulse on the 8-bit unit; lat = negedges until done (-1 on timeout)
  task automatic run8(input logic [7:0] av, input logic [7:0] bv, output int lat);
    @(negedge clk);
    a8 = av; b8 = bv; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    lat = 1;
    while (!done8 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!done8) lat = -1;
  endtask

  task automatic run16(input logic [15:0] av, input logic [7:0] bv, output int lat);
    @(negedge clk);
    a16 = av; b16 = bv; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    lat = 1;
    while (!done16 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!done16) lat = -1;
  endtask

  initial begin
    int lat;
    logic seen_done;

    reset_a = 1'b0;
    start8 = 1'b0;  a8 = '0;  b8 = '0;
    start16 = 1'b0; a16 = '0; b16 = '0;

    #1;
    chk("rst_state",   32'(state8),   32'h0);
    chk("rst_product", 32'(product8), 32'h0);
    chk("rst_flags",   32'({done8, busy8, err8}), 32'h0);
    chk("rst_count",   32'(count8),   32'h0);
    chk("rst_product16", 32'(product16), 32'h0);

    repeat (2) @(negedge clk);
    // first edge after release must accept start
    reset_a = 1'b1;
    a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;

    @(negedge clk);
    start8 = 1'b0;
    chk("ff_calc0_busy",  32'(busy8),  32'h1);
    chk("ff_calc0_state", 32'(state8), 32'h1);
    chk("ff_calc0_count", 32'(count8), 32'h0);
    chk("ff_calc0_done",  32'(done8),  32'h0);
    @(negedge clk);
    chk("ff_calc1_busy",  32'(busy8),  32'h1);
    chk("ff_calc1_count", 32'(count8), 32'h1);
    @(negedge clk);
    chk("ff_done",        32'(done8),    32'h1);
    chk("ff_done_busy",   32'(busy8),    32'h0);
    chk("ff_done_state",  32'(state8),   32'h4);
    chk("ff_product",     32'(product8), 32'(EXP_FF_FF));
    // start during DONE must be ignored
    start8 = 1'b1; a8 = 8'h03; b8 = 8'h05;
    @(negedge clk);
    chk("done_ign_state", 32'(state8),   32'h0);
    chk("done_one_cycle", 32'(done8),    32'h0);
    chk("prod_hold",      32'(product8), 32'(EXP_FF_FF));

    // start stays high: accepted from IDLE, then abort in 2nd CALC cycle
    @(negedge clk);
    start8 = 1'b0;
    chk("ab_calc0", 32'(state8), 32'h1);
    @(negedge clk);
    chk("ab_calc1_count", 32'(count8), 32'h1);
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    chk("ab_err",       32'(err8),     32'h1);
    chk("ab_err_state", 32'(state8),   32'h5);
    chk("ab_err_busy",  32'(busy8),    32'h0);
    chk("ab_product",   32'(product8), 32'(EXP_FF_FF));
    @(negedge clk);
    chk("ab_err_stay",  32'(state8),   32'h5);
    chk("ab_no_done",   32'(done8),    32'h0);

    run8(8'h03, 8'h05, lat);
    chk("rec_latency", 32'(lat),      32'd3);
    chk("rec_product", 32'(product8), 32'h000F);
    @(negedge clk);
    chk("rec_idle",    32'(state8),   32'h0);
    chk("rec_err_clr", 32'(err8),     32'h0);

    // asynchronous reset during the first CALC cycle
    a8 = 8'h77; b8 = 8'h77; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    chk("rc_busy_pre", 32'(busy8), 32'h1);
    reset_a = 1'b0;
    #1;
    chk("rc_state",   32'(state8),   32'h0);
    chk("rc_flags",   32'({done8, busy8, err8}), 32'h0);
    chk("rc_product", 32'(product8), 32'h0);
    chk("rc_count",   32'(count8),   32'h0);
    @(negedge clk);
    reset_a = 1'b1;
    seen_done = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (done8) seen_done = 1'b1;
    end
    chk("rc_no_done", 32'(seen_done), 32'h0);

    run8(8'h10, 8'h10, lat);
    chk("p10_latency", 32'(lat),      32'd3);
    chk("p10_product", 32'(product8), 32'h0100);

    run8(8'hFF, 8'h02, lat);
    chk("ff02_product", 32'(product8), 32'(EXP_FF_02));

    run8(8'h00, 8'hA5, lat);
    chk("zero_product", 32'(product8), 32'h0000);

    run16(16'h1234, 8'h56, lat);
    chk("w16_latency", 32'(lat),       32'd5);
    chk("w16_product", 32'(product16), 32'h061D78);

    run16(16'hFFFF, 8'hFF, lat);
    chk("w16_max_product", 32'(product16), 32'(EXP_FFFF_FF));
    @(negedge clk);
    chk("w16_idle", 32'(state16), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_mult_param.md
SEQ_MULT_PARAM -- requirements
Module: seq_mult_param

Interface
REQ-001 SHALL have parameter A_W, default 8: multiplicand A width; must be a multiple of DIG_W.
REQ-002 SHALL have parameter B_W, default 8: multiplier B width.
REQ-003 SHALL have parameter DIG_W, default 4: bits of A consumed per cycle; N = A_W/DIG_W, N >= 2.
REQ-004 SHALL have port clk  in  1: single clock, all state rising-edge.
REQ-005 SHALL have port reset_a  in  1: asynchronous, active-low reset.
REQ-006 SHALL have port start  in  1: request a new multiplication.
REQ-007 SHALL have port a  in  A_W: operand A, sampled on accepted start.
REQ-008 SHALL have port b  in  B_W: operand B, sampled on accepted start.
REQ-009 SHALL have port product  out  A_W+B_W: result register.
REQ-010 SHALL have port done  out  1: one-cycle pulse, product valid.
REQ-011 SHALL have port busy  out  1: high in CALC.
REQ-012 SHALL have port err  out  1: high in ERR.
REQ-013 SHALL have port state_out  out  3: current state encoding.
REQ-014 SHALL have port count_out  out  clog2(N): current digit index.

Function
REQ-015 SHALL use states IDLE=3'b000, CALC=3'b001, DONE=3'b100, ERR=3'b101; other codes go to ERR next cycle.
REQ-016 IDLE: start=1 -> latch a, b; clear accumulator and count; next CALC. start=0 -> stay IDLE.
REQ-017 CALC, each cycle: acc <= acc + (A digit[count] * B) << (count*DIG_W); count <= count+1.
REQ-018 CALC with count=N-1 and start=0 SHALL go to DONE, writing the final sum to product.
REQ-019 CALC with start=1 SHALL abort to ERR; product unchanged; accumulator discarded.
REQ-020 DONE SHALL assert done for exactly one cycle; next IDLE regardless of start (start in DONE ignored).
REQ-021 ERR: err=1 and stay while start=0; start=1 -> latch operands, clear acc/count, next CALC.
REQ-022 Latency: start accepted at edge t -> done high in cycle after edge t+N; product valid from that cycle.
REQ-023 product SHALL hold its value until the next DONE; never shows partial sums.
REQ-024 Accumulator SHALL be A_W+B_W bits; no truncation; unsigned max result (2^A_W-1)(2^B_W-1) exact.
REQ-025 count SHALL wrap to 0 on entry to CALC; never exceed N-1.
REQ-026 busy, done, err SHALL be registered-state decodes; never combinationally depend on start.

Reset
REQ-027 reset_a=0 SHALL immediately force IDLE, count=0, acc=0, product=0, done=0, busy=0, err=0.
REQ-028 Reset mid-CALC SHALL discard the operation; no done pulse after release.
REQ-029 First start SHALL be accepted on the first rising edge after reset_a deasserts.

Configuration
REQ-030 Macro SEQ_MULT_SIGNED_EN defined: a, b two's complement; product = signed(a)*signed(b), sign-extended to A_W+B_W.
REQ-031 Macro absent: a, b unsigned; no sign logic; latency and handshake identical in both builds.

Verification
REQ-032 Defaults, a=8'hFF, b=8'hFF, start pulse -> busy 2 cycles, done 3rd cycle, product=16'hFE01.
REQ-033 Defaults, a=8'h03, b=8'h05, start held 1 cycle then start=1 again in 2nd CALC cycle -> err=1, state_out=3'b101, product keeps old value; then start with a=8'h03, b=8'h05 -> product=16'h000F.
REQ-034 A_W=16, B_W=8, DIG_W=4, a=16'h1234, b=8'h56 -> done 5 cycles after start, product=24'h061D78.
REQ-035 Defaults, reset_a low during 1st CALC cycle -> all outputs 0 at once, no done pulse; next start 8'h10*8'h10 -> 16'h0100.
REQ-036 SEQ_MULT_SIGNED_EN, a=8'hFF, b=8'h02 -> product=16'hFFFE; without macro same inputs -> 16'h01FE.
